mac_accumulator_64b: RTL and testbench
======================================

# mac_accumulator_64b

Accumulation stage directly downstream of the 32x32 registered product stage. It consumes a stream of 64-bit unsigned products and sums a programmed number of them into a wide accumulator. It presents the completed sum on a valid/ready output port. Together with the product stage it forms a dot-product / MAC datapath.

## Interface

Parameters:

- `DATA_W`, default 64: width of each incoming product.
- `ACC_W`, default 72: accumulator and result width. Must be at least `DATA_W`.
- `LEN_W`, default 16: width of the term-count field.

Ports:

- `iClk` input 1: clock. All logic is on the rising edge.
- `iRstN` input 1: reset. Synchronous, active-low.
- `iClr` input 1: synchronous abort. Returns the block to IDLE and zeroes all state.
- `iStart` input 1: begin an accumulation. Sampled only in IDLE.
- `iLen` input `LEN_W`: number of products to sum. Sampled together with `iStart`.
- `iValid` input 1: a product is present on `iData`.
- `iData` input `DATA_W`: product from the upstream multiplier.
- `oReady` output 1: block accepts a product this cycle.
- `oValid` output 1: `oData` holds a completed sum.
- `oData` output `ACC_W`: accumulated sum.
- `iReady` input 1: downstream accepts the result.
- `oOvf` output 1: sticky flag. Set when the sum exceeded `ACC_W` bits during the current job.
- `oBusy` output 1: high whenever the block is not in IDLE.

## Operation

- The state machine has three states: IDLE, ACC and DONE.
- **IDLE**
  - `oReady`=0 and `oValid`=0.
  - On `iStart`=1 with `iLen`!=0: latch `iLen`, clear the accumulator, the term counter and `oOvf`, then go to ACC.
  - On `iStart`=1 with `iLen`=0: clear the accumulator and `oOvf`, then go directly to DONE. The result is 0.
- **ACC**
  - `oReady`=1, decoded combinationally from the state.
  - A beat is accepted when `iValid`=1 and `oReady`=1.
  - On each accepted beat: acc <= acc + zero-extend(`iData`), and cnt <= cnt+1.
  - When the accepted beat is term number `iLen` (cnt == len-1), go to DONE.
  - When `iValid`=0, nothing changes.
- **DONE**
  - `oValid`=1 and `oData`=acc, both held stable while `iReady`=0.
  - When `iReady`=1, go to IDLE.
  - `iStart` is ignored in DONE. There is a one-cycle IDLE bubble between jobs.
- **Arithmetic**
  - All operands are unsigned.
  - The sum is computed at `ACC_W`+1 bits.
  - A carry-out sets `oOvf`. The flag stays set until the next accepted `iStart`, `iClr` or reset.
- **Priority**: `iRstN`=0 > `iClr`=1 > normal operation.
  - `iClr` in any state, including mid-job: next cycle the state is IDLE and acc, cnt, `oData` and `oOvf` are all 0.
  - Beats offered in the same cycle as `iClr` are dropped.
- `iStart` in ACC or DONE has no effect.
- `iData` is ignored whenever `oReady`=0.

## Timing

- **Reset values**: state IDLE; `oData`=0, `oValid`=0, `oReady`=0, `oOvf`=0, `oBusy`=0. Accumulator and counter are 0.
- **Start**: `iStart` sampled at edge E. From cycle E+1, `oReady`=1 and `oBusy`=1.
- **Throughput**: one product per cycle when `iValid` is held high. An N-term job occupies exactly N ACC cycles.
- **Result latency**: last beat accepted at edge L. `oValid`=1 from cycle L+1, with the final sum including that last beat.
- **Release**: `iReady`=1 sampled at edge R while `oValid`=1. `oValid`=0 and the state is IDLE from R+1.
- `oData` is registered and changes only on accumulate, start, clear or reset edges.
- Counter limit: `iLen` = 2^`LEN_W`-1 must complete correctly, with no counter wrap before the end of the job.

## Configuration

- Macro: `MAC_ACC_SAT_EN`.
- **Defined**: on carry-out, the accumulator clamps to all-ones (2^`ACC_W`-1) and holds there for the rest of the job. `oOvf` is set.
- **Undefined**: the accumulator wraps modulo 2^`ACC_W`. `oOvf` is still set on carry-out.
- Handshake and timing are identical in both builds.

## Test plan

- **Basic sum**: `iLen`=3, beats 5, 7, 11 on consecutive cycles → `oValid` the cycle after the third beat, `oData`=23, `oOvf`=0. Hold `iReady`=0 for 4 cycles → `oData` stable. Then `iReady`=1 → `oValid`=0 and IDLE next cycle.
- **Gapped input**: `iLen`=4, beats 0xFFFFFFFE00000001 ×4 with `iValid` toggling 1,0,1,0,… → `oData`=0x3FFFFFFF800000004. Exactly 4 beats are consumed, and `oReady` drops after the 4th.
- **Zero length**: `iStart` with `iLen`=0 → `oValid`=1 next cycle, `oData`=0, `oReady` never asserted.
- **Overflow** (`ACC_W`=64): `iLen`=2, beats 0xFFFFFFFFFFFFFFFF and 2.
  - Without `MAC_ACC_SAT_EN`: `oData`=1, `oOvf`=1.
  - With `MAC_ACC_SAT_EN`: `oData`=0xFFFFFFFFFFFFFFFF, `oOvf`=1.
- **Abort**: `iLen`=5, assert `iClr` after 2 beats while `iValid`=1 → next cycle IDLE, `oData`=0, `oBusy`=0. A new job with `iLen`=1 and beat 9 → `oData`=9.
- **Reset mid-job and ignored start**:
  - `iRstN`=0 for one edge during ACC → all outputs at reset values on the next cycle.
  - `iStart` pulsed during ACC and during DONE → job length and result unaffected.

Source files
------------

// File: rtl/mac_accumulator_64b.sv
// Accumulates a programmed number of unsigned products into a wide sum and hands the sum off on a valid/ready port.
// Optional build macro MAC_ACC_SAT_EN: clamp the accumulator to all-ones on carry-out instead of wrapping.
module mac_accumulator_64b #(
    parameter int DATA_W = 64,
    parameter int ACC_W  = 72,
    parameter int LEN_W  = 16
) (
    input  logic              iClk,
    input  logic              iRstN,
    input  logic              iClr,
    input  logic              iStart,
    input  logic [LEN_W-1:0]  iLen,
    input  logic              iValid,
    input  logic [DATA_W-1:0] iData,
    output logic              oReady,
    output logic              oValid,
    output logic [ACC_W-1:0]  oData,
    input  logic              iReady,
    output logic              oOvf,
    output logic              oBusy
);

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t            state;
    state_t            stateNext;
    logic [ACC_W-1:0]  acc_p1;
    logic [LEN_W-1:0]  cnt_p1;
    logic [LEN_W-1:0]  len_p1;
    logic              ovf_p1;
    logic [ACC_W:0]    sum_p0;
    logic              beat;
    logic              lastBeat;

    function automatic logic [ACC_W:0] addWide(input logic [ACC_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
        return {1'b0, a} + {{(ACC_W + 1 - DATA_W){1'b0}}, b};
    endfunction

    function automatic logic [ACC_W-1:0] wrapOrSat(input logic [ACC_W:0] s);
`ifdef MAC_ACC_SAT_EN
        return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
`else
        return s[ACC_W-1:0];
`endif
    endfunction

    assign beat     = (state == ACC) && iValid;
    assign lastBeat = beat && (cnt_p1 == len_p1 - LEN_W'(1));
    assign sum_p0   = addWide(acc_p1, iData);

    always_ff @(posedge iClk) begin
        if (!iRstN) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        if (iClr) begin
            stateNext = IDLE;
        end else begin
            case (state)
                IDLE:    if (iStart) stateNext = (iLen != '0) ? ACC : DONE;
                ACC:     if (lastBeat) stateNext = DONE;
                DONE:    if (iReady) stateNext = IDLE;
                default: stateNext = IDLE;
            endcase
        end
    end

    always_comb begin
        oReady = (state == ACC);
        oValid = (state == DONE);
        oBusy  = (state != IDLE);
        oData  = acc_p1;
        oOvf   = ovf_p1;
    end

    // p0 -> p1: sum, term counter and sticky carry flag
    always_ff @(posedge iClk) begin
        if (!iRstN || iClr) begin
            acc_p1 <= '0;
            cnt_p1 <= '0;
            len_p1 <= '0;
            ovf_p1 <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (iStart) begin
                        acc_p1 <= '0;
                        cnt_p1 <= '0;
                        len_p1 <= iLen;
                        ovf_p1 <= 1'b0;
                    end
                end
                ACC: begin
                    if (beat) begin
                        acc_p1 <= wrapOrSat(sum_p0);
                        cnt_p1 <= cnt_p1 + LEN_W'(1);
                        if (sum_p0[ACC_W]) ovf_p1 <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_accumulator_64b.sv
// Directed bench for mac_accumulator_64b: a default 72-bit instance and a 64-bit instance share one stimulus stream.
module tb_mac_accumulator_64b;

    logic        clk;
    logic        rstN;
    logic        clr;
    logic        start;
    logic [15:0] len;
    logic        inValid;
    logic [63:0] inData;
    logic        dsReady;

    logic        rdy72, vld72, ovf72, busy72;
    logic [71:0] data72;
    logic        rdy64, vld64, ovf64, busy64;
    logic [63:0] data64;

    int nCompared = 0;
    int nMismatch = 0;

    mac_accumulator_64b dut (
        .iClk(clk), .iRstN(rstN), .iClr(clr), .iStart(start), .iLen(len),
        .iValid(inValid), .iData(inData), .oReady(rdy72), .oValid(vld72),
        .oData(data72), .iReady(dsReady), .oOvf(ovf72), .oBusy(busy72)
    );

    mac_accumulator_64b #(.ACC_W(64)) dut64 (
        .iClk(clk), .iRstN(rstN), .iClr(clr), .iStart(start), .iLen(len),
        .iValid(inValid), .iData(inData), .oReady(rdy64), .oValid(vld64),
        .oData(data64), .iReady(dsReady), .oOvf(ovf64), .oBusy(busy64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatch++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic release_();
        dsReady = 1'b1;
        tick();
        dsReady = 1'b0;
    endtask

    logic [63:0] ovfExp64;
    int          accepted;
    int          cycles;

    initial begin
        rstN = 1'b0; clr = 1'b0; start = 1'b0; len = '0;
        inValid = 1'b0; inData = '0; dsReady = 1'b0;
        tick(); tick();
        checkEq("rst_data", data72, 0);
        checkEq("rst_valid", vld72, 0);
        checkEq("rst_ready", rdy72, 0);
        checkEq("rst_ovf", ovf72, 0);
        checkEq("rst_busy", busy72, 0);
        checkEq("rst_busy64", {rdy64, vld64, busy64, ovf64}, 0);
        rstN = 1'b1;
        tick();

        // basic sum
        start = 1'b1; len = 16'd3; tick(); start = 1'b0;
        checkEq("basic_ready_e1", rdy72, 1);
        checkEq("basic_busy_e1", busy72, 1);
        inValid = 1'b1;
        inData = 64'd5;  tick();
        inData = 64'd7;  tick();
        inData = 64'd11; tick();
        inValid = 1'b0;
        checkEq("basic_valid", vld72, 1);
        checkEq("basic_data", data72, 23);
        checkEq("basic_ovf", ovf72, 0);
        checkEq("basic_ready_done", rdy72, 0);
        repeat (4) tick();
        checkEq("basic_hold_valid", vld72, 1);
        checkEq("basic_hold_data", data72, 23);
        release_();
        checkEq("basic_release_valid", vld72, 0);
        checkEq("basic_release_busy", busy72, 0);

        // gapped input
        start = 1'b1; len = 16'd4; tick(); start = 1'b0;
        accepted = 0;
        inData = 64'hFFFF_FFFE_0000_0001;
        for (int i = 0; i < 10; i++) begin
            inValid = (i % 2 == 0);
            if (rdy72 && inValid) accepted++;
            tick();
        end
        inValid = 1'b0;
        checkEq("gap_beats", accepted, 4);
        checkEq("gap_ready", rdy72, 0);
        checkEq("gap_valid", vld72, 1);
        checkEq("gap_data", data72, 72'h3_FFFF_FFF8_0000_0004);
        checkEq("gap_ovf64", ovf64, 1);
        release_();

        // zero length
        start = 1'b1; len = 16'd0; tick(); start = 1'b0;
        checkEq("zero_valid", vld72, 1);
        checkEq("zero_data", data72, 0);
        checkEq("zero_ready", rdy72, 0);
        release_();

        // overflow on the 64-bit instance
        start = 1'b1; len = 16'd2; tick(); start = 1'b0;
        checkEq("ovf_cleared_on_start", ovf64, 0);
        inValid = 1'b1;
        inData = 64'hFFFF_FFFF_FFFF_FFFF; tick();
        inData = 64'd2; tick();
        inValid = 1'b0;
`ifdef MAC_ACC_SAT_EN
        ovfExp64 = 64'hFFFF_FFFF_FFFF_FFFF;
`else
        ovfExp64 = 64'd1;
`endif
        checkEq("ovf64_valid", vld64, 1);
        checkEq("ovf64_data", data64, ovfExp64);
        checkEq("ovf64_flag", ovf64, 1);
        checkEq("ovf72_data", data72, 72'h1_0000_0000_0000_0001);
        checkEq("ovf72_flag", ovf72, 0);
        release_();
        checkEq("ovf64_sticky_idle", ovf64, 1);

        // abort mid-job
        start = 1'b1; len = 16'd5; tick(); start = 1'b0;
        inValid = 1'b1; inData = 64'd100;
        tick(); tick();
        clr = 1'b1; tick(); clr = 1'b0; inValid = 1'b0;
        checkEq("clr_busy", busy72, 0);
        checkEq("clr_data", data72, 0);
        checkEq("clr_ready", rdy72, 0);
        checkEq("clr_ovf64", ovf64, 0);
        start = 1'b1; len = 16'd1; tick(); start = 1'b0;
        inValid = 1'b1; inData = 64'd9; tick(); inValid = 1'b0;
        checkEq("after_clr_valid", vld72, 1);
        checkEq("after_clr_data", data72, 9);
        release_();

        // reset mid-job
        start = 1'b1; len = 16'd3; tick(); start = 1'b0;
        inValid = 1'b1; inData = 64'd4; tick();
        rstN = 1'b0; tick(); rstN = 1'b1; inValid = 1'b0;
        checkEq("midrst_outs", {rdy72, vld72, busy72, ovf72}, 0);
        checkEq("midrst_data", data72, 0);

        // start ignored in ACC and DONE
        start = 1'b1; len = 16'd3; tick(); start = 1'b0;
        inValid = 1'b1; inData = 64'd1; tick();
        start = 1'b1; len = 16'd0; inData = 64'd2; tick(); start = 1'b0;
        checkEq("ign_acc_ready", rdy72, 1);
        inData = 64'd3; tick(); inValid = 1'b0;
        checkEq("ign_acc_valid", vld72, 1);
        checkEq("ign_acc_data", data72, 6);
        start = 1'b1; len = 16'd7; tick(); start = 1'b0;
        checkEq("ign_done_data", data72, 6);
        release_();
        checkEq("ign_done_release", {vld72, busy72}, 0);

        // maximum term count
        start = 1'b1; len = 16'hFFFF; tick(); start = 1'b0;
        inValid = 1'b1; inData = 64'd1;
        cycles = 0;
        while (!vld72 && cycles < 70000) begin
            tick();
            cycles++;
        end
        inValid = 1'b0;
        checkEq("max_cycles", cycles, 65535);
        checkEq("max_data", data72, 65535);
        release_();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
